// File: rtl/dmac_ctrl_arbiter.sv
// dmac_ctrl_arbiter: round-robin arbiter that shares one mchan control target
// port between NB_REQ peripheral-bus requesters. The request path and the
// response path are both combinational. Each in-order response is routed back
// to the requester that issued it through an outstanding-transaction FIFO.
// Optional feature macro: DMAC_CTRL_ARB_LOCK_EN. When it is defined, a command
// write (add[4:0] == 0) locks arbitration to the writer for LOCK_WORDS more
// writes, or until the owner has been idle for 16 consecutive cycles.
module dmac_ctrl_arbiter #(
   parameter int NB_REQ          = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BE_WIDTH        = DATA_WIDTH / 8,
   parameter int PE_ID_WIDTH     = 1,
   parameter int MAX_OUTSTANDING = 4,
   parameter int LOCK_WORDS      = 3
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NB_REQ-1:0]                     req_i,
   input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]     add_i,
   input  logic [NB_REQ-1:0]                     wen_i,
   input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
   input  logic [NB_REQ-1:0][BE_WIDTH-1:0]       be_i,
   input  logic [NB_REQ-1:0][PE_ID_WIDTH-1:0]    id_i,
   output logic [NB_REQ-1:0]                     gnt_o,
   output logic [NB_REQ-1:0]                     r_valid_o,
   output logic [DATA_WIDTH-1:0]                 r_rdata_o,
   output logic                                  r_opc_o,
   output logic [PE_ID_WIDTH-1:0]                r_id_o,
   output logic                                  targ_req_o,
   output logic [ADDR_WIDTH-1:0]                 targ_add_o,
   output logic                                  targ_wen_o,
   output logic [DATA_WIDTH-1:0]                 targ_wdata_o,
   output logic [BE_WIDTH-1:0]                   targ_be_o,
   output logic [PE_ID_WIDTH-1:0]                targ_id_o,
   input  logic                                  targ_gnt_i,
   input  logic                                  targ_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                 targ_r_rdata_i,
   input  logic                                  targ_r_opc_i,
   input  logic [PE_ID_WIDTH-1:0]                targ_r_id_i,
   output logic                                  unexp_rsp_o
);

   localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = PTR_W + 1;

   // Reject configurations the pointer arithmetic cannot support.
   if (NB_REQ < 2 || MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
       LOCK_WORDS < 0 || ADDR_WIDTH < 5) begin : g_bad_cfg
      $error("dmac_ctrl_arbiter: unsupported parameter set");
   end

   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] win_idx;
   logic             win_valid;
   logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             unexp_q;
   logic [IDX_W-1:0] head_idx;

`ifdef DMAC_CTRL_ARB_LOCK_EN
   localparam int LCW = (LOCK_WORDS > 1) ? $clog2(LOCK_WORDS + 1) : 1;

   typedef enum logic {LK_FREE, LK_HELD} lock_state_e;

   lock_state_e      lock_st_q, lock_st_d;
   logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [3:0]       idle_cnt_q, idle_cnt_d;
   logic             win_write;
`endif

   assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign head_idx   = fifo_q[rd_ptr_q];

   // Pick the first requester at or above rr_ptr (wrapping); a held lock overrides the search.
   always_comb begin : arb_search
      int unsigned cand;
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         cand = 32'(rr_ptr_q) + i;
         if (cand >= NB_REQ) cand = cand - NB_REQ;
         if (!win_valid && req_i[IDX_W'(cand)]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
`ifdef DMAC_CTRL_ARB_LOCK_EN
      if (lock_st_q == LK_HELD) begin
         win_valid = req_i[lock_owner_q];
         win_idx   = lock_owner_q;
      end
`endif
   end

   assign targ_req_o   = win_valid && !fifo_full;
   assign targ_add_o   = win_valid ? add_i[win_idx]   : '0;
   assign targ_wen_o   = win_valid ? wen_i[win_idx]   : 1'b0;
   assign targ_wdata_o = win_valid ? wdata_i[win_idx] : '0;
   assign targ_be_o    = win_valid ? be_i[win_idx]    : '0;
   assign targ_id_o    = win_valid ? id_i[win_idx]    : '0;

   assign push = targ_req_o && targ_gnt_i;
   assign pop  = targ_r_valid_i && !fifo_empty;

   // Grant goes only to the winner, and only on a completed handshake.
   always_comb begin
      gnt_o = '0;
      if (push) gnt_o[win_idx] = 1'b1;
   end

   // Response valid is steered to the requester at the FIFO head.
   always_comb begin
      r_valid_o = '0;
      if (pop) r_valid_o[head_idx] = 1'b1;
   end

   assign r_rdata_o   = targ_r_valid_i ? targ_r_rdata_i : '0;
   assign r_opc_o     = targ_r_valid_i ? targ_r_opc_i   : 1'b0;
   assign r_id_o      = targ_r_valid_i ? targ_r_id_i    : '0;
   assign unexp_rsp_o = unexp_q;

   // Routing FIFO storage; contents are only meaningful below count_q.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= win_idx;
   end

   // Round-robin pointer, FIFO pointers/occupancy and the sticky unexpected-response flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         unexp_q  <= 1'b0;
      end else begin
         if (push) begin
            rr_ptr_q <= (win_idx == IDX_W'(NB_REQ - 1)) ? '0 : win_idx + 1'b1;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (targ_r_valid_i && fifo_empty) unexp_q <= 1'b1;
      end
   end

`ifdef DMAC_CTRL_ARB_LOCK_EN
   assign win_write = push && !wen_i[win_idx];

   // Lock next-state: take on a command write, count owner writes, release on last word or idle timeout.
   always_comb begin
      lock_st_d    = lock_st_q;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = lock_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      case (lock_st_q)
         LK_FREE: begin
            if (win_write && add_i[win_idx][4:0] == 5'd0 && LOCK_WORDS != 0) begin
               lock_st_d    = LK_HELD;
               lock_owner_d = win_idx;
               lock_cnt_d   = LCW'(LOCK_WORDS);
               idle_cnt_d   = '0;
            end
         end
         LK_HELD: begin
            // A grant while held always belongs to the owner, whose req_i is then high,
            // so the word-count release and the idle release never fire together.
            if (!req_i[lock_owner_q]) begin
               if (idle_cnt_q == 4'd15) begin
                  lock_st_d  = LK_FREE;
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end else begin
               idle_cnt_d = '0;
            end
            if (win_write) begin
               if (lock_cnt_q == LCW'(1)) lock_st_d = LK_FREE;
               lock_cnt_d = lock_cnt_q - 1'b1;
            end
         end
         default: lock_st_d = LK_FREE;
      endcase
   end

   // Lock state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_st_q    <= LK_FREE;
         lock_owner_q <= '0;
         lock_cnt_q   <= '0;
         idle_cnt_q   <= '0;
      end else begin
         lock_st_q    <= lock_st_d;
         lock_owner_q <= lock_owner_d;
         lock_cnt_q   <= lock_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// tb_dmac_ctrl_arbiter: self-checking bench for dmac_ctrl_arbiter.
// A queue-based reference model predicts grants and response routing.
// Lock-feature scenarios are compiled when DMAC_CTRL_ARB_LOCK_EN is defined.
module tb_dmac_ctrl_arbiter;

   localparam int NB   = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int IW   = 1;
   localparam int MAXO = 4;
   localparam int LW   = 3;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NB-1:0]            req;
   logic [NB-1:0][AW-1:0]    add;
   logic [NB-1:0]            wen;
   logic [NB-1:0][DW-1:0]    wdata;
   logic [NB-1:0][BW-1:0]    be;
   logic [NB-1:0][IW-1:0]    id;
   logic [NB-1:0]            gnt;
   logic [NB-1:0]            r_valid;
   logic [DW-1:0]            r_rdata;
   logic                     r_opc;
   logic [IW-1:0]            r_id;
   logic                     t_req;
   logic [AW-1:0]            t_add;
   logic                     t_wen;
   logic [DW-1:0]            t_wdata;
   logic [BW-1:0]            t_be;
   logic [IW-1:0]            t_id;
   logic                     t_gnt;
   logic                     t_rv;
   logic [DW-1:0]            t_rdata;
   logic                     t_opc;
   logic [IW-1:0]            t_rid;
   logic                     unexp;

   dmac_ctrl_arbiter #(
      .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
      .PE_ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO), .LOCK_WORDS(LW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be), .id_i(id),
      .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc), .r_id_o(r_id),
      .targ_req_o(t_req), .targ_add_o(t_add), .targ_wen_o(t_wen), .targ_wdata_o(t_wdata),
      .targ_be_o(t_be), .targ_id_o(t_id), .targ_gnt_i(t_gnt),
      .targ_r_valid_i(t_rv), .targ_r_rdata_i(t_rdata), .targ_r_opc_i(t_opc), .targ_r_id_i(t_rid),
      .unexp_rsp_o(unexp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   int            m_q[$];
   int            m_rr;
   bit            m_unexp;
   bit            m_lock;
   int            m_owner;
   int            m_left;
   int            m_idle;
   int            e_win;
   bit            e_treq;
   logic [NB-1:0] e_gnt;
   logic [NB-1:0] e_rv;

   function automatic void model_reset();
      m_q.delete();
      m_rr = 0; m_unexp = 0; m_lock = 0; m_owner = 0; m_left = 0; m_idle = 0;
   endfunction

   function automatic void model_eval();
      e_win = -1;
      if (m_lock) begin
         if (req[m_owner]) e_win = m_owner;
      end else begin
         for (int k = 0; k < NB; k++) begin
            int j = (m_rr + k) % NB;
            if (e_win < 0 && req[j]) e_win = j;
         end
      end
      e_treq = (e_win >= 0) && (m_q.size() < MAXO);
      e_gnt = '0;
      if (e_treq && t_gnt) e_gnt[e_win] = 1'b1;
      e_rv = '0;
      if (t_rv && m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
   endfunction

   function automatic void model_commit();
      bit hs;
      model_eval();
      hs = e_treq && t_gnt;
      if (t_rv) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         else m_unexp = 1;
      end
`ifdef DMAC_CTRL_ARB_LOCK_EN
      if (m_lock) begin
         if (!req[m_owner]) begin
            m_idle++;
            if (m_idle == 16) begin m_lock = 0; m_idle = 0; end
         end else m_idle = 0;
      end
`endif
      if (hs) begin
         m_q.push_back(e_win);
         m_rr = (e_win + 1) % NB;
`ifdef DMAC_CTRL_ARB_LOCK_EN
         if (m_lock) begin
            if (!wen[e_win]) begin
               m_left--;
               if (m_left == 0) m_lock = 0;
            end
         end else if (!wen[e_win] && add[e_win][4:0] == 5'd0 && LW > 0) begin
            m_lock = 1; m_owner = e_win; m_left = LW; m_idle = 0;
         end
`endif
      end
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic clear_inputs();
      req = '0; add = '0; wen = '1; wdata = '0; be = '0; id = '0;
      t_gnt = 1'b0; t_rv = 1'b0; t_rdata = '0; t_opc = 1'b0; t_rid = '0;
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      #2 rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      req = '0; t_gnt = 1'b0;
      for (int k = 0; k < MAXO + 1 && m_q.size() > 0; k++) begin
         t_rv = 1'b1; t_rdata = $urandom;
         advance();
      end
      t_rv = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (t_req !== 1'b0) begin n_bad++; $display("FAIL reset_treq got=%b exp=0", t_req); end
      n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL reset_unexp got=%b exp=0", unexp); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      n_cmp++; if (r_valid !== '0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=000", r_valid); end
      n_cmp++; if (t_add !== '0 || r_rdata !== '0) begin n_bad++; $display("FAIL reset_data got add=%h rdata=%h exp=0", t_add, r_rdata); end
      advance();
   endtask

   task automatic test_round_robin();
      int ord[6] = '{0, 1, 2, 0, 1, 2};
      logic [NB-1:0] cg;
      req = '1; wen = '1; t_gnt = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) req = '0;
         t_rv = (c > 0); t_rdata = $urandom; t_rid = IW'($urandom);
         @(negedge clk);
         model_eval();
         cg = '0; if (c < 6) cg[ord[c]] = 1'b1;
         n_cmp++; if (gnt !== cg) begin n_bad++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", c, gnt, cg); end
         n_cmp++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", c, gnt, e_gnt); end
         cg = '0; if (c > 0) cg[ord[c-1]] = 1'b1;
         n_cmp++; if (r_valid !== cg) begin n_bad++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", c, r_valid, cg); end
         if (c > 0) begin
            n_cmp++; if (r_rdata !== t_rdata || r_id !== t_rid) begin n_bad++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", c, r_rdata, t_rdata); end
         end
         advance();
      end
      t_rv = 1'b0;
   endtask

   task automatic test_full();
      drain();
      req = '1; t_gnt = 1'b1; t_rv = 1'b0;
      for (int c = 0; c < 8; c++) begin
         t_rv = (c == 6);
         @(negedge clk);
         model_eval();
         n_cmp++; if (t_req !== (c < 4 || c == 7)) begin n_bad++; $display("FAIL full_treq cyc=%0d got=%b exp=%b", c, t_req, (c < 4 || c == 7)); end
         n_cmp++; if (gnt !== e_gnt || r_valid !== e_rv) begin n_bad++; $display("FAIL full_model cyc=%0d got gnt=%b rv=%b exp gnt=%b rv=%b", c, gnt, r_valid, e_gnt, e_rv); end
         if (c == 7) begin
            n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL full_regrant got=%b exp=010", gnt); end
         end
         advance();
      end
      drain();
   endtask

   task automatic test_push_pop();
      logic [NB-1:0] xg[7] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
      logic [NB-1:0] xr[7] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
      req = '1; wen = '1; t_gnt = 1'b1;
      for (int c = 0; c < 7; c++) begin
         t_rv = (c == 2 || c == 3);
         @(negedge clk);
         model_eval();
         n_cmp++; if (gnt !== xg[c]) begin n_bad++; $display("FAIL pp_gnt cyc=%0d got=%b exp=%b", c, gnt, xg[c]); end
         n_cmp++; if (r_valid !== xr[c]) begin n_bad++; $display("FAIL pp_rvalid cyc=%0d got=%b exp=%b", c, r_valid, xr[c]); end
         n_cmp++; if (gnt !== e_gnt || r_valid !== e_rv) begin n_bad++; $display("FAIL pp_model cyc=%0d got gnt=%b rv=%b exp gnt=%b rv=%b", c, gnt, r_valid, e_gnt, e_rv); end
         advance();
      end
      req = '0; t_gnt = 1'b0;
      for (int c = 0; c < 4; c++) begin
         t_rv = 1'b1;
         @(negedge clk);
         model_eval();
         n_cmp++; if (r_valid !== e_rv) begin n_bad++; $display("FAIL pp_drain cyc=%0d got=%b exp=%b", c, r_valid, e_rv); end
         advance();
      end
      t_rv = 1'b0;
   endtask

   task automatic test_unexpected();
      req = '0; t_gnt = 1'b0; t_rv = 1'b1; t_rdata = $urandom;
      @(negedge clk);
      n_cmp++; if (r_valid !== '0) begin n_bad++; $display("FAIL unexp_rvalid got=%b exp=000", r_valid); end
      n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL unexp_early got=%b exp=0", unexp); end
      advance();
      t_rv = 1'b0; req = '1; t_gnt = 1'b1;
      for (int c = 0; c < 5; c++) begin
         t_rv = (c > 0);
         @(negedge clk);
         model_eval();
         n_cmp++; if (unexp !== m_unexp) begin n_bad++; $display("FAIL unexp_sticky cyc=%0d got=%b exp=%b", c, unexp, m_unexp); end
         advance();
      end
      clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (unexp !== 1'b0) begin n_bad++; $display("FAIL unexp_clear got=%b exp=0", unexp); end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      req = 3'b011; t_gnt = 1'b1;
      repeat (3) advance();
      req = '0; t_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (gnt !== '0 || r_valid !== '0 || t_req !== 1'b0 || unexp !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_outs got gnt=%b rv=%b treq=%b unexp=%b exp all 0", gnt, r_valid, t_req, unexp);
      end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      req = '1; t_gnt = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL mid_rrptr got=%b exp=001", gnt); end
      advance();
      req = '0; t_gnt = 1'b0;
      for (int c = 0; c < 3; c++) begin
         t_rv = (c < 2);
         @(negedge clk);
         model_eval();
         n_cmp++; if (r_valid !== e_rv || unexp !== m_unexp) begin
            n_bad++; $display("FAIL mid_post cyc=%0d got rv=%b unexp=%b exp rv=%b unexp=%b", c, r_valid, unexp, e_rv, m_unexp);
         end
         advance();
      end
      n_cmp++; if (unexp !== 1'b1) begin n_bad++; $display("FAIL mid_stale_rsp got=%b exp=1", unexp); end
      do_reset();
   endtask

`ifdef DMAC_CTRL_ARB_LOCK_EN
   task automatic test_lock_cmd();
      logic [NB-1:0] xg[4] = '{3'b010, 3'b010, 3'b010, 3'b100};
      do_reset();
      req = 3'b001; t_gnt = 1'b1;
      advance();
      req = '1; wen = 3'b101; add[1] = '0; t_rv = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt !== 3'b010) begin n_bad++; $display("FAIL lock_cmd got=%b exp=010", gnt); end
      advance();
      for (int c = 0; c < 4; c++) begin
         add[1] = AW'(4 * (c + 1));
         @(negedge clk);
         model_eval();
         n_cmp++; if (gnt !== xg[c]) begin n_bad++; $display("FAIL lock_words cyc=%0d got=%b exp=%b", c, gnt, xg[c]); end
         n_cmp++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL lock_model cyc=%0d got=%b exp=%b", c, gnt, e_gnt); end
         advance();
      end
      do_reset();
   endtask

   task automatic test_lock_timeout();
      do_reset();
      req = 3'b001; t_gnt = 1'b1;
      advance();
      req = 3'b010; wen = 3'b101; add[1] = '0; t_rv = 1'b1;
      advance();
      req = 3'b101;
      for (int c = 1; c <= 17; c++) begin
         t_rv = (m_q.size() > 0);
         @(negedge clk);
         model_eval();
         n_cmp++; if (gnt !== ((c == 17) ? 3'b100 : 3'b000)) begin
            n_bad++; $display("FAIL lock_timeout cyc=%0d got=%b exp=%b", c, gnt, (c == 17) ? 3'b100 : 3'b000);
         end
         advance();
      end
      do_reset();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         t_gnt = ($urandom_range(0, 3) != 0);
         t_rv  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         t_rdata = $urandom; t_opc = 1'($urandom); t_rid = IW'($urandom);
         @(negedge clk);
         model_eval();
         n_cmp++; if (gnt !== e_gnt || t_req !== e_treq) begin
            n_bad++; $display("FAIL rnd_gnt cyc=%0d got gnt=%b treq=%b exp gnt=%b treq=%b", c, gnt, t_req, e_gnt, e_treq);
         end
         n_cmp++; if (r_valid !== e_rv || unexp !== m_unexp) begin
            n_bad++; $display("FAIL rnd_rsp cyc=%0d got rv=%b unexp=%b exp rv=%b unexp=%b", c, r_valid, unexp, e_rv, m_unexp);
         end
         if (e_treq) begin
            n_cmp++; if (t_add !== add[e_win] || t_wen !== wen[e_win] || t_wdata !== wdata[e_win] ||
                         t_be !== be[e_win] || t_id !== id[e_win]) begin
               n_bad++; $display("FAIL rnd_fwd cyc=%0d got add=%h wdata=%h exp add=%h wdata=%h", c, t_add, t_wdata, add[e_win], wdata[e_win]);
            end
         end
         if (t_rv) begin
            n_cmp++; if (r_rdata !== t_rdata || r_opc !== t_opc || r_id !== t_rid) begin
               n_bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, r_rdata, t_rdata);
            end
         end
         advance();
         // Requesters keep requests and fields stable until granted.
         for (int i = 0; i < NB; i++) begin
            bit granted = e_treq && t_gnt && (e_win == i);
            if (granted || !req[i]) begin
               req[i] = ($urandom_range(0, 9) < 5);
               add[i] = {$urandom & 32'hFFFF_FFE0} | (($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 31)));
               wen[i] = 1'($urandom); wdata[i] = $urandom; be[i] = BW'($urandom); id[i] = IW'($urandom);
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_round_robin();
      test_full();
      test_push_pop();
      test_unexpected();
      test_reset_mid();
`ifdef DMAC_CTRL_ARB_LOCK_EN
      test_lock_cmd();
      test_lock_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmac_ctrl_arbiter.md
# dmac_ctrl_arbiter

Round-robin arbiter that shares one mchan control target port between `NB_REQ` peripheral-bus requesters (cluster cores, FC, future decompressor). It sits between the control slaves and mchan's control target. It forwards one request per cycle with zero added request latency. It routes each in-order response back to the requester that issued it, using an outstanding-transaction FIFO. Optionally, it locks arbitration across a multi-word DMA command sequence so command words from different requesters never interleave.

## Interface
Parameters:
- `NB_REQ`, 3, number of requesters (≥2)
- `ADDR_WIDTH`, 32, control address width
- `DATA_WIDTH`, 32, data width
- `BE_WIDTH`, `DATA_WIDTH/8`, byte-enable width
- `PE_ID_WIDTH`, 1, transaction ID width
- `MAX_OUTSTANDING`, 4, routing FIFO depth (power of 2, ≥2)
- `LOCK_WORDS`, 3, words following a command word that stay locked (lock feature only)

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset; asynchronous, active-low (already decided)
- `req_i` in `[NB_REQ]`: request
- `add_i` in `[NB_REQ][ADDR_WIDTH]`: address
- `wen_i` in `[NB_REQ]`: 1 = read, 0 = write
- `wdata_i` in `[NB_REQ][DATA_WIDTH]`: write data
- `be_i` in `[NB_REQ][BE_WIDTH]`: byte enables
- `id_i` in `[NB_REQ][PE_ID_WIDTH]`: ID
- `gnt_o` out `[NB_REQ]`: grant
- `r_valid_o` out `[NB_REQ]`: response valid
- `r_rdata_o` out `DATA_WIDTH`: response data, broadcast to all requesters
- `r_opc_o` out 1: response error, broadcast
- `r_id_o` out `PE_ID_WIDTH`: response ID, broadcast
- `targ_req_o`, `targ_add_o`, `targ_wen_o`, `targ_wdata_o`, `targ_be_o`, `targ_id_o` out: forwarded request
- `targ_gnt_i` in 1: target grant
- `targ_r_valid_i`, `targ_r_rdata_i`, `targ_r_opc_i`, `targ_r_id_i` in: target response
- `unexp_rsp_o` out 1: sticky error flag; set on a response that arrives while the FIFO is empty

## Operation
- Winner: the first requester with `req_i` set, searching from `rr_ptr` upward and wrapping modulo `NB_REQ`.
- The winner's request fields drive the `targ_*` outputs combinationally.
- `targ_req_o` = winner valid && FIFO not full.
- `gnt_o[w]` = `targ_gnt_i && targ_req_o`. All other bits of `gnt_o` are 0.
- On a handshake (request + grant):
  - push `w` into the routing FIFO;
  - set `rr_ptr` to `(w+1) mod NB_REQ`.
- With no handshake, `rr_ptr` holds.
- FIFO full (`count == MAX_OUTSTANDING`): `targ_req_o` = 0 and no grant. There is no same-cycle pop bypass.
- Response path:
  - `r_valid_o[head]` = `targ_r_valid_i`; the data, opc and ID outputs pass straight through.
  - The FIFO pops on `targ_r_valid_i`.
  - The target responds in order with exactly one response per grant.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `targ_r_valid_i` while the FIFO is empty: no `r_valid_o` bit is asserted, `unexp_rsp_o` is set, and the flag clears only on reset.
- Requesters must hold `req_i` and all fields stable until granted. A requester that deasserts `req_i` before grant is simply no longer considered.

## Timing
- Request path is combinational: 0 cycles added. Response path is combinational: 0 cycles added.
- The arbitration result depends only on registered state (`rr_ptr`, `count`, lock state) and current-cycle `req_i`. There is no path from `targ_gnt_i` to `targ_req_o`.
- Reset values:
  - `rr_ptr` = 0; FIFO empty; `unexp_rsp_o` = 0; unlocked.
  - All outputs are 0 while `req_i` = 0 and `targ_r_valid_i` = 0.
- Reset mid-operation flushes the FIFO. Responses that arrive after reset for pre-reset grants raise `unexp_rsp_o`.
- Throughput: one grant per cycle sustained while responses drain in step.

## Configuration
- Macro: `DMAC_CTRL_ARB_LOCK_EN`.
- Defined:
  - A granted write with `add[4:0] == 0` (the command register) locks the arbiter to that requester. The lock counter loads `LOCK_WORDS`.
  - While locked, only the lock owner can win, and each granted write by the owner decrements the counter.
  - The lock releases on the grant that brings the counter to 0, or immediately if the owner deasserts `req_i` for 16 consecutive cycles (timeout counter).
  - `rr_ptr` updates normally on each owner grant.
- Undefined: no lock state is built; pure round-robin.

## Test plan
- Reset, then `req_i=3'b111` held with `targ_gnt_i=1` and responses returned the next cycle → grants in order 0,1,2,0,1,2; each `r_valid_o` lands on the issuing requester one cycle after its grant.
- `MAX_OUTSTANDING=4`, `targ_gnt_i=1`, no responses → exactly 4 grants, then `targ_req_o=0`. One response frees a slot, and the next grant happens in the following cycle.
- Push and pop in the same cycle at `count=2` → `count` stays 2; the head routes correctly.
- `targ_r_valid_i=1` with the FIFO empty → no `r_valid_o` bit set; `unexp_rsp_o=1` and it stays 1 until `rst_ni` goes low.
- Assert `rst_ni` low with 3 outstanding → all outputs 0 asynchronously; after release, `rr_ptr=0` and the FIFO is empty.
- With `DMAC_CTRL_ARB_LOCK_EN` and `LOCK_WORDS=3`:
  - requester 1 writes address 0x0 while requester 0 and requester 2 request continuously → the next 3 grants all go to requester 1, then requester 2 is granted;
  - requester 1 idles for 16 cycles after the command write → the lock releases.
